// File: rtl/phy_tx_scheduler.sv
// Round-robin byte-slot scheduler with burst limit feeding the PHY TX serializer.
// Optional `PHY_TX_RETRAIN_EN adds a retrain input that re-enters link training.
module phy_tx_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int TRAIN_BYTES = 4,
  parameter int BURST_MAX   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef PHY_TX_RETRAIN_EN
  input  logic                 retrain,
`endif
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [NUM_REQ-1:0]   tx_grant,
  output logic [2:0]           bit_cnt,
  output logic                 link_up
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {TRAIN, ACTIVE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [3:0]           train_q, train_d;
  logic [3:0]           burst_q, burst_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        last_q, last_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 link_q, link_d;

  logic                 found;
  logic                 others;
  logic                 arb;
  logic [PW-1:0]        win;
  logic [PW-1:0]        cand;
  logic [NUM_REQ-1:0]   oh_win;
  logic [NUM_REQ-1:0]   rdy;
  logic [3:0]           burst_inc;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return PW'(s);
  endfunction

  // Circular search for the first valid requester starting at the pointer
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    cand  = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = nxt(rr_q, i);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    oh_win = NUM_REQ'(1) << win;
    others = |(req_valid & ~oh_win);
    if (win == last_q)
      burst_inc = (burst_q >= 4'(BURST_MAX)) ? 4'(BURST_MAX)
                                              : burst_q + 4'd1;
    else
      burst_inc = 4'd1;
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q + 3'd1;
    train_d = train_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    link_d  = link_q;
    arb     = 1'b0;
    rdy     = '0;
    if (bit_q == 3'd7) begin
      unique case (state_q)
        TRAIN: begin
          train_d = train_q + 4'd1;
          data_d  = 8'h00;
          valid_d = 1'b0;
          grant_d = '0;
          if (train_q == 4'(TRAIN_BYTES - 1)) begin
            arb     = 1'b1;
            state_d = ACTIVE;
            link_d  = 1'b1;
          end
        end
        ACTIVE: begin
`ifdef PHY_TX_RETRAIN_EN
          if (retrain) begin
            state_d = TRAIN;
            train_d = 4'd0;
            link_d  = 1'b0;
            data_d  = 8'h00;
            valid_d = 1'b0;
            grant_d = '0;
          end else begin
            arb = 1'b1;
          end
`else
          arb = 1'b1;
`endif
        end
        default: ;
      endcase
    end
    if (arb) begin
      if (found) begin
        rdy     = oh_win;
        data_d  = req_data[8*int'(win) +: 8];
        valid_d = 1'b1;
        grant_d = oh_win;
        burst_d = burst_inc;
        last_d  = win;
        // Burst exhausted while someone else waits: hand the pointer on
        rr_d    = (burst_inc >= 4'(BURST_MAX) && others) ? nxt(win, 1) : win;
      end else begin
        data_d  = 8'h00;
        valid_d = 1'b0;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= TRAIN;
      bit_q   <= 3'd0;
      train_q <= 4'd0;
      burst_q <= 4'd0;
      rr_q    <= '0;
      last_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      grant_q <= '0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      train_q <= train_d;
      burst_q <= burst_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      link_q  <= link_d;
    end
  end

  assign req_ready = reset ? rdy : '0;
  assign tx_data   = data_q;
  assign tx_valid  = valid_q;
  assign tx_grant  = grant_q;
  assign bit_cnt   = bit_q;
  assign link_up   = link_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: directed slot checks plus randomized
// traffic against a slot-level arbitration model.
module tb_phy_tx_scheduler;

  localparam int N  = 2;
  localparam int TB = 4;
  localparam int BM = 4;

  logic           clk;
  logic           reset;
  logic           rt;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic [N-1:0]   tx_grant;
  logic [2:0]     bit_cnt;
  logic           link_up;

  int n_tests;
  int n_fail;

  phy_tx_scheduler #(
    .NUM_REQ(N),
    .TRAIN_BYTES(TB),
    .BURST_MAX(BM)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef PHY_TX_RETRAIN_EN
    .retrain(rt),
`endif
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_grant(tx_grant),
    .bit_cnt(bit_cnt),
    .link_up(link_up)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Slot-level model: cycle index since reset release, the cycle at
  // which the link becomes active, and the round-robin history.
  int         m_cyc, m_end, m_ptr, m_last, m_run;
  bit         m_init;
  logic [7:0] e_data;
  logic       e_valid;
  logic [N-1:0] e_grant;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int n_valid(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  initial m_init = 1'b0;

  always @(negedge clk) begin
    int w;
    bit arb;
    bit active;
    logic [N-1:0] e_rdy;
    #2;
    w      = winner(req_valid, m_ptr);
    active = m_init && (m_cyc >= m_end);
    arb    = m_init && reset && (m_cyc % 8 == 7) && (m_cyc + 1 >= m_end)
             && !(rt && active);
    e_rdy  = (arb && w >= 0) ? (N'(1) << w) : '0;
    if (m_init) begin
      chk("bit_cnt", 32'(bit_cnt), 32'(m_cyc % 8));
      chk("link_up", 32'(link_up), 32'(active));
      chk("tx_valid", 32'(tx_valid), 32'(e_valid));
      chk("tx_data", 32'(tx_data), 32'(e_data));
      chk("tx_grant", 32'(tx_grant), 32'(e_grant));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
    end
    if (!reset) begin
      m_init  = 1'b1;
      m_cyc   = 0;
      m_end   = 8 * TB;
      m_ptr   = 0;
      m_last  = 0;
      m_run   = 0;
      e_data  = 8'h00;
      e_valid = 1'b0;
      e_grant = '0;
    end else if (m_init) begin
      if (m_cyc % 8 == 7) begin
        e_data  = 8'h00;
        e_valid = 1'b0;
        e_grant = '0;
        if (rt && active) begin
          m_end = m_cyc + 1 + 8 * TB;
        end else if (arb && w >= 0) begin
          e_data  = req_data[8*w +: 8];
          e_valid = 1'b1;
          e_grant = N'(1) << w;
          m_run   = (w == m_last) ? m_run + 1 : 1;
          m_last  = w;
          if (m_run >= BM && n_valid(req_valid) > 1) m_ptr = (w + 1) % N;
          else m_ptr = w;
        end
      end
      m_cyc++;
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] v,
                       input logic [8*N-1:0] d, input logic t);
    @(negedge clk);
    reset     = r;
    req_valid = v;
    req_data  = d;
    rt        = t;
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  logic [N-1:0] own [9];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    rt        = 1'b0;
    req_valid = '0;
    req_data  = '0;
    own = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // Idle link: training then comma slots
    do_reset(5);
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 2'b00, 16'h0000, 1'b0);
      if (c == 0)  chk("lit_rst_bit", 32'(bit_cnt), 32'd0);
      if (c == 0)  chk("lit_rst_gnt", 32'(tx_grant), 32'd0);
      if (c == 13) chk("lit_bit13", 32'(bit_cnt), 32'd5);
      if (c == 31) chk("lit_link31", 32'(link_up), 32'd0);
      if (c == 32) chk("lit_link32", 32'(link_up), 32'd1);
      if (c == 36) chk("lit_idle_v", 32'(tx_valid), 32'd0);
    end

    // Single requester streams
    do_reset(3);
    for (int c = 0; c < 48; c++) begin
      drive(1'b1, 2'b01, 16'h00A5, 1'b0);
      if (c == 30) chk("lit_rdy30", 32'(req_ready), 32'd0);
      if (c == 31) chk("lit_rdy31", 32'(req_ready), 32'd1);
      if (c == 32) chk("lit_data32", 32'(tx_data), 32'hA5);
      if (c == 39) chk("lit_gnt39", 32'(tx_grant), 32'd1);
      if (c == 44) chk("lit_data44", 32'(tx_data), 32'hA5);
      if (c == 47) chk("lit_v47", 32'(tx_valid), 32'd1);
    end

    // Two requesters, burst limit rotation
    do_reset(2);
    for (int c = 0; c < 8 * 13; c++) begin
      drive(1'b1, 2'b11, 16'h2211, 1'b0);
      if (c >= 32 && c % 8 == 3) chk("lit_owner", 32'(tx_grant), 32'(own[c/8-4]));
      if (c == 67) chk("lit_data_s8", 32'(tx_data), 32'h22);
    end

    // Requester 0 drops, then nobody valid
    do_reset(2);
    for (int c = 0; c < 60; c++) begin
      drive(1'b1, (c < 47) ? 2'b11 : (c < 55) ? 2'b10 : 2'b00, 16'h2211, 1'b0);
      if (c == 48) chk("lit_drop_gnt", 32'(tx_grant), 32'd2);
      if (c == 48) chk("lit_drop_dat", 32'(tx_data), 32'h22);
      if (c == 56) chk("lit_none_v", 32'(tx_valid), 32'd0);
      if (c == 56) chk("lit_none_g", 32'(tx_grant), 32'd0);
    end

    // Reset in the middle of a data slot
    do_reset(2);
    for (int c = 0; c < 44; c++) drive(1'b1, 2'b01, 16'h00A5, 1'b0);
    drive(1'b0, 2'b01, 16'h00A5, 1'b0);
    drive(1'b0, 2'b01, 16'h00A5, 1'b0);
    chk("lit_mid_v", 32'(tx_valid), 32'd0);
    chk("lit_mid_bit", 32'(bit_cnt), 32'd0);
    chk("lit_mid_link", 32'(link_up), 32'd0);
    chk("lit_mid_dat", 32'(tx_data), 32'd0);
    for (int c = 0; c < 34; c++) begin
      drive(1'b1, 2'b01, 16'h00A5, 1'b0);
      if (c == 31) chk("lit_re_rdy", 32'(req_ready), 32'd1);
      if (c == 32) chk("lit_re_v", 32'(tx_valid), 32'd1);
    end

`ifdef PHY_TX_RETRAIN_EN
    do_reset(2);
    for (int c = 0; c < 110; c++) begin
      drive(1'b1, 2'b11, 16'h2211, c == 63);
      if (c == 64) chk("lit_rt_link0", 32'(link_up), 32'd0);
      if (c == 70) chk("lit_rt_comma", 32'(tx_valid), 32'd0);
      if (c == 95) chk("lit_rt_link95", 32'(link_up), 32'd0);
      if (c == 96) chk("lit_rt_link96", 32'(link_up), 32'd1);
      if (c == 96) chk("lit_rt_gnt", 32'(tx_grant), 32'd2);
    end
`endif

    // Randomized traffic with occasional resets and retrains
    do_reset(1);
    for (int c = 0; c < 5000; c++) begin
      logic [N-1:0] v;
      logic t;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) != 0);
      t = 1'b0;
`ifdef PHY_TX_RETRAIN_EN
      t = ($urandom_range(0, 29) == 0);
`endif
      drive(($urandom_range(0, 499) != 0), v, 16'($urandom), t);
    end

    drive(1'b1, '0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
